// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequencer and round-key store for an AES-128 key expander.
// It accepts a cipher key, pulses the expander's kld for one cycle, and captures
// the expander's NRND+1 round keys into a store. Any stored key can then be read
// by index, one cycle after the index is presented.
// Optional feature: define AES_KEY_ZEROIZE_EN to add a zeroize input that wipes
// all key material and returns the controller to IDLE.
module aes_key_sched_ctrl #(
  parameter int NRND  = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             key_vld,
  output logic             key_rdy,
  input  logic [127:0]     key_in,
  output logic             kld_o,
  output logic [127:0]     key_o,
  input  logic [31:0]      wo_0,
  input  logic [31:0]      wo_1,
  input  logic [31:0]      wo_2,
  input  logic [31:0]      wo_3,
  output logic             busy,
  output logic             rk_valid,
  input  logic [IDX_W-1:0] rk_rd_idx,
  output logic [127:0]     rk_rd_data
);

  localparam int               DEPTH    = NRND + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRND);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] rnd;
  logic [127:0]     store [DEPTH];
  logic             zero;
  logic             accept;
  logic             last_rnd;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif

  // Zeroize blocks the handshake so a key offered alongside it is dropped.
  assign key_rdy  = ((state == IDLE) || (state == READY)) && !zero;
  assign accept   = key_vld && key_rdy;
  assign last_rnd = (rnd == LAST_IDX);

  // Next-state decode for the load/expand sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE, READY: if (accept)   state_nx = LOAD;
      LOAD:                      state_nx = EXPAND;
      EXPAND:      if (last_rnd) state_nx = READY;
      default:                   state_nx = IDLE;
    endcase
    if (zero) state_nx = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Registered control outputs, key register and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kld_o    <= 1'b0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      key_o    <= '0;
      rnd      <= '0;
    end else begin
      // kld_o follows the accept edge, so it is high only for the LOAD cycle.
      kld_o    <= accept;
      busy     <= (state_nx == LOAD) || (state_nx == EXPAND);
      rk_valid <= (state_nx == READY);
      if (zero) begin
        key_o <= '0;
        rnd   <= '0;
      end else begin
        if (accept)           key_o <= key_in;
        if (state == EXPAND)  rnd   <= last_rnd ? '0 : rnd + 1'b1;
      end
    end
  end

  // Round-key store: one entry captured per EXPAND cycle, wiped by reset or zeroize.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the store is reset on purpose; key material must not survive a reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (zero) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (state == EXPAND) begin
      store[rnd] <= {wo_0, wo_1, wo_2, wo_3};
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rk_rd_data <= '0;
    else if (zero)                  rk_rd_data <= '0;
    else if (rk_rd_idx <= LAST_IDX) rk_rd_data <= store[rk_rd_idx];
    else                            rk_rd_data <= '0;
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench for aes_key_sched_ctrl.
// A behavioural expander drives wo_0..wo_3: the FIPS-197 key expands to its
// published round keys, any other key k to k ^ {4{r * 32'h01010101}}.
// Stimulus pushes expected values with a due cycle; a monitor compares them.
// Define AES_KEY_ZEROIZE_EN to also exercise the zeroize input.
module tb_aes_key_sched_ctrl;
  localparam int NRND  = 10;
  localparam int IDX_W = 4;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] K3 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] K4 = 128'hdeadbeefcafef00d0badc0de8badf00d;
  localparam logic [127:0] K5 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K6 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K7 = 128'h5a5a5a5aa5a5a5a53c3c3c3cc3c3c3c3;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_vld;
  logic             key_rdy;
  logic [127:0]     key_in;
  logic             kld_o;
  logic [127:0]     key_o;
  logic [31:0]      wo_0, wo_1, wo_2, wo_3;
  logic             busy;
  logic             rk_valid;
  logic [IDX_W-1:0] rk_rd_idx;
  logic [127:0]     rk_rd_data;
`ifdef AES_KEY_ZEROIZE_EN
  logic             zeroize;
`endif

  aes_key_sched_ctrl #(.NRND(NRND), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_vld    (key_vld),
    .key_rdy    (key_rdy),
    .key_in     (key_in),
    .kld_o      (kld_o),
    .key_o      (key_o),
    .wo_0       (wo_0),
    .wo_1       (wo_1),
    .wo_2       (wo_2),
    .wo_3       (wo_3),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail  = 0;
  int   kld_cnt = 0;
  int   cap_cnt = 0;
  logic prev_kld = 1'b0;

  typedef enum int {K_RD, K_VALID, K_BUSY, K_KLD, K_RDY, K_KEYO, K_KLDCNT, K_CAPCNT} kind_t;
  typedef struct {
    int           due;
    kind_t        kind;
    logic [127:0] exp;
    string        name;
  } item_t;
  item_t sb[$];

  // Reference round key r of key k; indices beyond NRND read as zero.
  function automatic logic [127:0] rk_model(input logic [127:0] k, input int r);
    logic [31:0] m;
    if (r < 0 || r > NRND) return '0;
    if (k == FIPS_KEY) return fips_rk[r];
    m = 32'h01010101 * 32'(r);
    return k ^ {m, m, m, m};
  endfunction

  // Behavioural expander: loads key_o while kld_o is high, then steps one round per cycle.
  logic [127:0] xb = '0;
  int           xr = 0;
  initial forever begin
    @(posedge clk);
    if (kld_o === 1'b1) begin
      xb <= key_o;
      xr <= 0;
    end else if (xr < 15) begin
      xr <= xr + 1;
    end
  end
  assign {wo_0, wo_1, wo_2, wo_3} = rk_model(xb, xr);

  // Cycle counter; stable whenever the monitor samples on the falling edge.
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int due, input kind_t kind, input logic [127:0] exp, input string name);
    item_t it;
    it.due  = due;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  function automatic logic [127:0] observe(input kind_t k);
    case (k)
      K_RD:     return rk_rd_data;
      K_VALID:  return 128'(rk_valid);
      K_BUSY:   return 128'(busy);
      K_KLD:    return 128'(kld_o);
      K_RDY:    return 128'(key_rdy);
      K_KEYO:   return key_o;
      K_KLDCNT: return 128'(kld_cnt);
      default:  return 128'(cap_cnt);
    endcase
  endfunction

  // Monitor: counts kld pulses and capture cycles, then retires every due expectation.
  initial begin : monitor
    int i;
    forever begin
      @(negedge clk);
      if (kld_o === 1'b1) begin
        kld_cnt++;
        check("kld_single_cycle", 128'(prev_kld), 128'd0);
      end
      if (busy === 1'b1 && kld_o === 1'b0) cap_cnt++;
      prev_kld = kld_o;
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due <= cyc) begin
          check(sb[i].name, observe(sb[i].kind), sb[i].exp);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  // Offer a key (called on a falling edge) and wait, bounded, for it to be accepted.
  // a is the cycle number after the accepting edge.
  task automatic handshake(input logic [127:0] key, input bit sched, output int a);
    bit ok;
    ok = 1'b0;
    a  = 0;
    key_in  = key;
    key_vld = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (key_rdy === 1'b1) begin
        ok = 1'b1;
        a  = cyc + 1;
        expect_at(a, K_KLD,   128'd1, "kld_on_load");
        expect_at(a, K_BUSY,  128'd1, "busy_on_load");
        expect_at(a, K_KEYO,  key,    "key_o_capture");
        expect_at(a, K_VALID, 128'd0, "valid_fall_on_accept");
        expect_at(a, K_RDY,   128'd0, "rdy_low_in_load");
        if (sched) begin
          expect_at(a + 1,  K_KLD,   128'd0, "kld_one_cycle");
          expect_at(a + 1,  K_BUSY,  128'd1, "busy_expand");
          expect_at(a + 11, K_VALID, 128'd0, "valid_not_early");
          expect_at(a + 11, K_BUSY,  128'd1, "busy_last_capture");
          expect_at(a + 12, K_VALID, 128'd1, "valid_latency");
          expect_at(a + 12, K_BUSY,  128'd0, "busy_ready");
          expect_at(a + 12, K_RDY,   128'd1, "rdy_in_ready");
        end
      end
      @(negedge clk);
    end
    check("key_accepted", 128'(ok), 128'd1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic rd(input int idx, input logic [127:0] exp, input string name);
    rk_rd_idx = IDX_W'(idx);
    expect_at(cyc + 1, K_RD, exp, name);
    @(negedge clk);
  endtask

  task automatic load_and_read(input logic [127:0] key);
    int a;
    handshake(key, 1'b1, a);
    key_vld = 1'b0;
    wait_until(a + 12);
    rd(0,  key,              "rd_idx0_is_key");
    rd(5,  rk_model(key, 5), "rd_idx5");
    rd(10, rk_model(key, 10), "rd_idx10");
    rd(11, 128'd0,           "rd_idx11_zero");
    rd(15, 128'd0,           "rd_idx15_zero");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a;
    int b;
    int t;
    int kc;
    int cc;
    rst_n     = 1'b0;
    key_vld   = 1'b0;
    key_in    = '0;
    rk_rd_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + 1, K_VALID, 128'd0, "rst_valid");
    expect_at(cyc + 1, K_BUSY,  128'd0, "rst_busy");
    expect_at(cyc + 1, K_KLD,   128'd0, "rst_kld");
    expect_at(cyc + 1, K_KEYO,  128'd0, "rst_key_o");
    expect_at(cyc + 1, K_RDY,   128'd1, "rst_rdy_idle");
    expect_at(cyc + 1, K_RD,    128'd0, "rst_rd_data");
    @(negedge clk);

    // FIPS-197 key: full schedule, every index including out-of-range ones.
    handshake(FIPS_KEY, 1'b1, a);
    key_vld = 1'b0;
    wait_until(a + 12);
    for (int i = 0; i < 16; i++) rd(i, rk_model(FIPS_KEY, i), "fips_rk");
    rd(1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_idx1");
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_idx10");

    // Reset while rnd==5 in EXPAND.
    handshake(K2, 1'b0, a);
    key_vld = 1'b0;
    expect_at(a + 5, K_BUSY, 128'd1, "busy_before_reset");
    wait_until(a + 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_at(cyc, K_VALID, 128'd0, "reset_mid_valid");
    expect_at(cyc, K_BUSY,  128'd0, "reset_mid_busy");
    expect_at(cyc, K_KLD,   128'd0, "reset_mid_kld");
    expect_at(cyc, K_KEYO,  128'd0, "reset_mid_key_o");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(5, 128'd0, "store_cleared_by_reset");
    t = cyc + 10;
    expect_at(t, K_VALID, 128'd0, "no_partial_valid");
    wait_until(t);
    load_and_read(K2);

    // Second key held during EXPAND: ignored until READY, then accepted.
    handshake(K3, 1'b1, a);
    expect_at(a + 6, K_KEYO, K3,     "key_o_held_in_expand");
    expect_at(a + 6, K_RDY,  128'd0, "rdy_low_in_expand");
    handshake(K4, 1'b1, b);
    check("accept_cycle_after_valid", 128'(b), 128'(a + 13));
    key_vld = 1'b0;
    wait_until(b + 12);
    rd(0,  K4,              "second_sched_idx0");
    rd(10, rk_model(K4, 10), "second_sched_idx10");

    // Three back-to-back keys: three kld pulses, 33 capture cycles.
    #1;
    kc = kld_cnt;
    cc = cap_cnt;
    handshake(K5, 1'b1, a);
    handshake(K6, 1'b1, a);
    handshake(K7, 1'b1, a);
    key_vld = 1'b0;
    wait_until(a + 12);
    expect_at(cyc + 1, K_KLDCNT, 128'(kc + 3),  "kld_pulse_count");
    expect_at(cyc + 1, K_CAPCNT, 128'(cc + 33), "capture_count");
    rd(0, K7,               "b2b_last_idx0");
    rd(7, rk_model(K7, 7),  "b2b_last_idx7");

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize in READY wipes everything.
    rk_rd_idx = IDX_W'(3);
    zeroize   = 1'b1;
    expect_at(cyc + 1, K_VALID, 128'd0, "zeroize_valid");
    expect_at(cyc + 1, K_BUSY,  128'd0, "zeroize_busy");
    expect_at(cyc + 1, K_KEYO,  128'd0, "zeroize_key_o");
    expect_at(cyc + 1, K_RD,    128'd0, "zeroize_rd_data");
    @(negedge clk);
    zeroize = 1'b0;
    for (int i = 0; i <= NRND; i++) rd(i, 128'd0, "zeroized_store");
    // Zeroize together with a key offer: the key is dropped.
    key_in  = K2;
    key_vld = 1'b1;
    zeroize = 1'b1;
    expect_at(cyc + 1, K_RDY,  128'd0, "rdy_low_during_zeroize");
    expect_at(cyc + 1, K_KLD,  128'd0, "zeroize_drops_key_kld");
    expect_at(cyc + 1, K_KEYO, 128'd0, "zeroize_drops_key_o");
    @(negedge clk);
    #1;
    key_vld = 1'b0;
    zeroize = 1'b0;
    expect_at(cyc + 1, K_BUSY,  128'd0, "idle_after_zeroize");
    expect_at(cyc + 1, K_VALID, 128'd0, "invalid_after_zeroize");
    @(negedge clk);
`endif

    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
